// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl: one-at-a-time request/response front end driving the dram pins.
// Optional atomic fetch-and-add is built when DRAM_ACCESS_FETCH_ADD_EN is defined.
module dram_access_ctrl #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
  output logic                         resp_err,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
  output logic                         mem_read_not_write,
  output logic                         mem_cs,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;

`ifdef DRAM_ACCESS_FETCH_ADD_EN
  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, WRITE, RESP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, RESP
  } state_t;
`endif

  state_t     state;
  state_t     state_nx;
  logic [1:0] op_q;
  logic       req_legal;
  logic       accept;
  logic       access;
  logic       writing;

`ifdef DRAM_ACCESS_FETCH_ADD_EN
  logic [DATA_BUS_WIDTH-1:0] addend_q;
  assign req_legal = (req_op == OP_LOAD) || (req_op == OP_STORE) ||
                     (req_op == OP_FADD);
`else
  assign req_legal = (req_op == OP_LOAD) || (req_op == OP_STORE);
`endif

  assign accept = (state == IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake / pin decode
  always_comb begin
    state_nx = state;
    access   = 1'b0;
    writing  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nx = req_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        access   = 1'b1;
        writing  = (op_q == OP_STORE);
        state_nx = (op_q == OP_STORE) ? RESP : CAPTURE;
      end
      CAPTURE: begin
`ifdef DRAM_ACCESS_FETCH_ADD_EN
        state_nx = (op_q == OP_FADD) ? WRITE : RESP;
`else
        state_nx = RESP;
`endif
      end
`ifdef DRAM_ACCESS_FETCH_ADD_EN
      WRITE: begin
        access   = 1'b1;
        writing  = 1'b1;
        state_nx = RESP;
      end
`endif
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    req_ready          = (state == IDLE) && !rst;
    resp_valid         = (state == RESP);
    mem_cs             = access && !rst;
    mem_read_not_write = !(writing && !rst);
  end

  // Request latch, read capture, and the held address / write-data pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= OP_LOAD;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
`ifdef DRAM_ACCESS_FETCH_ADD_EN
      addend_q       <= '0;
`endif
    end else if (accept) begin
      op_q       <= req_op;
      resp_rdata <= '0;
      resp_err   <= !req_legal;
      if (req_legal) mem_address <= req_addr;
      if (req_op == OP_STORE) mem_write_data <= req_wdata;
`ifdef DRAM_ACCESS_FETCH_ADD_EN
      addend_q   <= req_wdata;
`endif
    end else if (state == CAPTURE) begin
      resp_rdata <= mem_read_data;
`ifdef DRAM_ACCESS_FETCH_ADD_EN
      if (op_q == OP_FADD) mem_write_data <= mem_read_data + addend_q;
`endif
    end else if ((state == RESP) && resp_ready) begin
      resp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb_dram_access_ctrl: randomized self-checking bench with a dram model
// and a request-level reference model (shadow memory + latency rules).
module tb_dram_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 24;
`ifdef DRAM_ACCESS_FETCH_ADD_EN
  localparam bit FA_EN = 1'b1;
`else
  localparam bit FA_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_not_write;
  logic          mem_cs;
  wire  [DW-1:0] mem_read_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] dmem [0:65535];
  logic [DW-1:0] shadow [0:65535];
  logic [DW-1:0] rd_q = '0;
  logic          rd_vld = 1'b0;

  always #5 clk = ~clk;

  dram_access_ctrl #(
    .ADDRESS_BUS_WIDTH(AW),
    .DATA_BUS_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_not_write(mem_read_not_write),
    .mem_cs(mem_cs),
    .mem_read_data(mem_read_data)
  );

  // dram: registered read, write on the select edge, Z when not presenting data
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_read_not_write) rd_q <= dmem[mem_address];
      else dmem[mem_address] <= mem_write_data;
    end
    rd_vld <= mem_cs && mem_read_not_write;
  end
  assign mem_read_data = rd_vld ? rd_q : 'z;

  // Reference model: result, latency and access counts of one request
  task automatic model(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                       output bit err, output int lat, output int ncs,
                       output int nwr);
    rd = '0; err = 1'b0; lat = 1; ncs = 0; nwr = 0;
    if (op == 2'b00) begin
      rd = shadow[a]; lat = 3; ncs = 1;
    end else if (op == 2'b01) begin
      shadow[a] = wd; lat = 2; ncs = 1; nwr = 1;
    end else if (op == 2'b10 && FA_EN) begin
      rd = shadow[a];
      shadow[a] = DW'((shadow[a] + wd) % (1 << DW));
      lat = 4; ncs = 2; nwr = 1;
    end else begin
      err = 1'b1;
    end
  endtask

  // Issue one request; observe latency, pin activity and the response
  task automatic run_req(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int stall,
                         output int lat, output logic [DW-1:0] rd,
                         output bit err, output int ncs, output int nwr,
                         output bit addr_ok, output bit stall_ok);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    lat = 0; ncs = 0; nwr = 0; addr_ok = 1'b1;
    forever begin
      @(negedge clk);
      lat++;
      if (mem_cs === 1'b1) begin
        ncs++;
        if (mem_read_not_write === 1'b0) nwr++;
        if (mem_address !== a) addr_ok = 1'b0;
      end
      if (resp_valid === 1'b1 || lat > 20) break;
    end
    if (resp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL resp_valid_timeout got=%b want=1", resp_valid);
    end
    rd = resp_rdata; err = resp_err; stall_ok = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== err ||
          req_ready !== 1'b0 || mem_cs !== 1'b0) stall_ok = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  // Issue a request and compare every observation with the model
  task automatic check_req(input string nm, input logic [1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] rd, erd;
    bit err, eerr, aok, sok;
    int lat, elat, ncs, encs, nwr, enwr;
    model(op, a, wd, erd, eerr, elat, encs, enwr);
    run_req(op, a, wd, 0, lat, rd, err, ncs, nwr, aok, sok);
    checks++;
    if (rd !== erd) begin
      failures++; $display("FAIL %s rdata got=%h want=%h", nm, rd, erd);
    end
    checks++;
    if (err !== eerr) begin
      failures++; $display("FAIL %s err got=%b want=%b", nm, err, eerr);
    end
    checks++;
    if (lat != elat) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, elat);
    end
    checks++;
    if (ncs != encs || nwr != enwr) begin
      failures++;
      $display("FAIL %s cs/wr got=%0d/%0d want=%0d/%0d", nm, ncs, nwr, encs, enwr);
    end
    checks++;
    if (!aok) begin
      failures++; $display("FAIL %s address got=wrong want=%h", nm, a);
    end
    checks++;
    if (dmem[a] !== shadow[a]) begin
      failures++; $display("FAIL %s mem got=%h want=%h", nm, dmem[a], shadow[a]);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_cs, mem_read_not_write} !== 5'b00001 ||
        resp_rdata !== '0 || mem_address !== '0 || mem_write_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b want=00001", req_ready,
               resp_valid, resp_err, mem_cs, mem_read_not_write);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_idle_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_load();
    dmem[16] = 24'd10; shadow[16] = 24'd10;
    check_req("load16", 2'b00, 16'd16, 24'd0);
  endtask

  task automatic test_store_load();
    check_req("store5", 2'b01, 16'd5, 24'h00ABCD);
    check_req("load5", 2'b00, 16'd5, 24'd0);
  endtask

  task automatic test_fetch_add();
    dmem[32] = 24'd23; shadow[32] = 24'd23;
    check_req("fadd32", 2'b10, 16'd32, 24'd7);
    check_req("load32", 2'b00, 16'd32, 24'd0);
    dmem[40] = 24'hFFFFFF; shadow[40] = 24'hFFFFFF;
    check_req("fadd_wrap", 2'b10, 16'd40, 24'd2);
    check_req("op11", 2'b11, 16'd41, 24'd5);
  endtask

  task automatic test_stall();
    logic [DW-1:0] rd;
    bit err, aok, sok;
    int lat, ncs, nwr;
    dmem[9] = 24'h123456; shadow[9] = 24'h123456;
    run_req(2'b00, 16'd9, 24'd0, 5, lat, rd, err, ncs, nwr, aok, sok);
    checks++;
    if (!sok || rd !== 24'h123456) begin
      failures++; $display("FAIL stall_hold got=%b/%h want=1/123456", sok, rd);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got=%b%b want=01", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    dmem[7] = 24'd3; shadow[7] = 24'd3;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 16'd7; req_wdata = 24'h000055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (mem_cs !== 1'b1) begin
      failures++; $display("FAIL midrst_issue got=%b want=1", mem_cs);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_cs, mem_read_not_write} !== 5'b00001 ||
        mem_address !== '0 || mem_write_data !== '0 || resp_rdata !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b%b%b%b%b want=00001", req_ready,
               resp_valid, resp_err, mem_cs, mem_read_not_write);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dmem[7] !== 24'd3) begin
      failures++; $display("FAIL midrst_mem got=%h want=3", dmem[7]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      check_req("random", op, AW'($urandom_range(0, 15)), DW'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = DW'($urandom);
      shadow[i] = dmem[i];
    end
    test_reset();
    test_load();
    test_store_load();
    test_fetch_add();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
